// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: state/class enums, opcode and ALU-op constants shared by the sequencer
package rv_ctrl_pkg;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;
  typedef enum logic [2:0] {
    C_LW    = 3'd0,
    C_SW    = 3'd1,
    C_ITYPE = 3'd2,
    C_RTYPE = 3'd3,
    C_BR    = 3'd4
  } iclass_t;
  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [3:0] ALU_ADD   = 4'h3;
  localparam logic [3:0] ALU_FUNCT = 4'h1;
  localparam logic [3:0] ALU_SUB   = 4'h2;
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts mem_ready-low cycles (clear/waiting/ready in, expired out)
module mem_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic waiting,
  input  logic ready,
  output logic expired
);
  localparam int W = $clog2(WAIT_MAX + 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clear ? '0 : (waiting && !ready) ? cnt_q + W'(1) : cnt_q;
  // a handshake in the same cycle the limit is reached wins over the timeout
  assign expired = waiting && !ready && (cnt_q == W'(WAIT_MAX));
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: FETCH/DECODE/EXEC/MEM/WB control FSM; opcode/branch_taken/mem_ready in, datapath enables, flags, retired count out
module multicycle_sequencer
  import rv_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic [3:0]       alu_op,
  output logic             alu_src,
  output logic             reg_we,
  output logic             mem_to_reg,
  output logic             busy,
  output logic             illegal,
  output logic             timeout,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state_dbg
);
  state_t state_q, state_d;
  iclass_t cls_q, cls_d, dec_cls;
  logic illegal_q, illegal_d, timeout_q, timeout_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic expired, dec_ok, retire, waiting, timer_clear, is_mem_op;
  state_t after_boundary;
  always_comb begin
    dec_cls = opcode == OP_LW ? C_LW : opcode == OP_SW ? C_SW : opcode == OP_ITYPE ? C_ITYPE :
              opcode == OP_RTYPE ? C_RTYPE : C_BR;
    dec_ok = opcode inside {OP_LW, OP_SW, OP_ITYPE, OP_RTYPE, OP_BRANCH};
    is_mem_op = cls_q == C_LW || cls_q == C_SW;
    retire = (state_q == S_EXEC && cls_q == C_BR) || (state_q == S_MEM && cls_q == C_SW && mem_ready) ||
             state_q == S_WB;
    after_boundary = start ? S_FETCH : S_IDLE;
    case (state_q)
      S_IDLE:   state_d = start ? S_FETCH : S_IDLE;
      S_FETCH:  state_d = mem_ready ? S_DECODE : expired ? S_HALT : S_FETCH;
      S_DECODE: state_d = dec_ok ? S_EXEC : S_HALT;
      S_EXEC:   state_d = cls_q == C_BR ? after_boundary : is_mem_op ? S_MEM : S_WB;
      S_MEM:    state_d = mem_ready ? (cls_q == C_SW ? after_boundary : S_WB) : expired ? S_HALT : S_MEM;
      S_WB:     state_d = after_boundary;
      default:  state_d = S_HALT;
    endcase
    cls_d = (state_q == S_DECODE && dec_ok) ? dec_cls : cls_q;
    illegal_d = illegal_q || (state_q == S_DECODE && !dec_ok);
    timeout_d = timeout_q || expired;
    retired_d = retired_q + CNT_W'(retire);
    waiting = state_q == S_FETCH || state_q == S_MEM;
    // SW completing in MEM goes straight back to FETCH, so clear on any state change into a waiting state
    timer_clear = (state_d == S_FETCH || state_d == S_MEM) && state_d != state_q;
  end
  mem_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .waiting (waiting),
    .ready   (mem_ready),
    .expired (expired)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q   <= S_IDLE;
      cls_q     <= C_LW;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      retired_q <= retired_d;
    end
  // enables decode from the state flops, so they all fall the instant reset asserts
  assign mem_req    = waiting;
  assign mem_we     = state_q == S_MEM && cls_q == C_SW;
  assign ir_we      = state_q == S_FETCH && mem_ready;
  assign pc_we      = retire;
  assign pc_src     = state_q == S_EXEC && cls_q == C_BR && branch_taken;
  assign alu_op     = (state_q == S_EXEC || state_q == S_MEM) ?
                      (is_mem_op ? ALU_ADD : cls_q == C_BR ? ALU_SUB : ALU_FUNCT) : 4'h0;
  assign alu_src    = (state_q == S_EXEC || state_q == S_MEM) && (is_mem_op || cls_q == C_ITYPE);
  assign reg_we     = state_q == S_WB;
  assign mem_to_reg = state_q == S_WB && cls_q == C_LW;
  assign busy       = state_q != S_IDLE && state_q != S_HALT;
  assign illegal    = illegal_q;
  assign timeout    = timeout_q;
  assign retired    = retired_q;
  assign state_dbg  = state_q;
endmodule
